ibuf_issue_ctrl: RTL and testbench
==================================

IBUF_ISSUE_CTRL -- requirements
Module: ibuf_issue_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port flush, input, 1: pipeline flush from commit.
REQ-005 SHALL have port id_ready, input, 1: decode/ID stage can accept instructions this cycle.
REQ-006 SHALL have ports a_valid, b_valid, input, 1 each: the instruction-buffer head and head+1 entries are valid.
REQ-007 SHALL have ports a_is_spec_op, a_is_idle, a_have_excp, a_is_br, input, 1 each: head-entry attributes (a_is_br = br_type not none).
REQ-008 SHALL have ports b_is_spec_op, b_is_idle, b_have_excp, b_is_br, input, 1 each: head+1 entry attributes.
REQ-009 SHALL have ports a_dest, b_dest, b_r1, b_r2, input, 5 each: register indices.
REQ-010 SHALL have port b_src2_is_imm, input, 1: b_r2 is not read when set.
REQ-011 SHALL have port serial_done, input, 1: the serialising instruction has committed.
REQ-012 SHALL have port intr_pending, input, 1: interrupt pending; wakes from idle.
REQ-013 SHALL have port o_size, output, 2: entries popped from the buffer this cycle (0..2).
REQ-014 SHALL have port state, output, 2: current FSM state encoding.
REQ-015 SHALL have ports stall_cnt and dual_cnt, output, CNT_W each: performance counters.

Function
REQ-016 SHALL implement FSM states RUN=0, SERIAL=1 and IDLE_WAIT=2; encoding 3 is unreachable and SHALL decode as RUN.
REQ-017 SHALL compute o_size combinationally from the current state and inputs, with zero-cycle latency to the buffer pop.
REQ-018 SHALL drive o_size=0 when flush=1, when state is not RUN, when id_ready=0, or when a_valid=0.
REQ-019 SHALL, in RUN, drive o_size=1 when any of a_is_spec_op, a_is_idle, a_have_excp or a_is_br is set.
REQ-020 SHALL, in RUN, drive o_size=2 only when all of the following hold; otherwise o_size=1:
  - b_valid=1
  - none of b_is_spec_op, b_is_idle, b_have_excp is set
  - no hazard on a_dest: a_dest is 0, or (a_dest differs from b_r1, a_dest differs from b_dest, and either b_src2_is_imm=1 or a_dest differs from b_r2)
REQ-021 SHALL transition RUN->SERIAL when o_size is at least 1 and (a_is_spec_op or a_have_excp) is set.
REQ-022 SHALL transition RUN->IDLE_WAIT when o_size is at least 1 and a_is_idle=1; a_is_idle has priority over a_is_spec_op.
REQ-023 SHALL transition SERIAL->RUN on serial_done=1.
REQ-024 SHALL transition IDLE_WAIT->RUN on intr_pending=1.
REQ-025 SHALL force the next state to RUN on flush=1, overriding every other transition, including one coincident with serial_done or intr_pending.
REQ-026 SHALL increment stall_cnt by 1 per cycle with a_valid=1, o_size=0 and flush=0, saturating at all-ones.
REQ-027 SHALL increment dual_cnt by 1 per cycle with o_size=2, wrapping modulo 2^CNT_W.
REQ-028 SHALL NOT clear the counters on flush.
REQ-029 SHALL never drive o_size=2 when b_valid=0, and never drive o_size=3.

Reset
REQ-030 SHALL, while resetn=0, immediately set state=RUN, stall_cnt=0 and dual_cnt=0, independent of clk.
REQ-031 SHALL hold o_size=0 while resetn=0.
REQ-032 SHALL allow issue from the first rising clk edge after resetn deasserts.
REQ-033 SHALL return to RUN with cleared counters on a reset asserted mid-SERIAL or mid-IDLE_WAIT.

Verification
REQ-034 SHALL cover independent pair: RUN, both valid, a_dest=5, b_r1=6, b_r2=7, b_dest=8, id_ready=1 -> o_size=2, dual_cnt 0->1.
REQ-035 SHALL cover RAW hazard: a_dest=5, b_r2=5, b_src2_is_imm=0 -> o_size=1; same with b_src2_is_imm=1 -> o_size=2; a_dest=0, b_r1=0 -> o_size=2.
REQ-036 SHALL cover serialisation: a_is_spec_op=1 issued -> o_size=1, state=1 next cycle; o_size=0 for 3 cycles with a_valid=1 -> stall_cnt=3; serial_done=1 -> state=0.
REQ-037 SHALL cover idle wake: a_is_idle=1 issued -> state=2; intr_pending=1 -> state=0 next cycle, issue resumes.
REQ-038 SHALL cover flush priority: flush=1 coincident with serial_done=0 in SERIAL -> o_size=0 that cycle, state=0 next cycle.
REQ-039 SHALL cover saturation and async reset: stall_cnt preloaded near all-ones stays at 0xFFFF; resetn pulse mid-cycle -> counters 0 and state 0 before the next edge.

Source files
------------

// File: rtl/ibuf_issue_ctrl.sv
// Issue control between the instruction buffer and the decode stage: pops 0..2
// entries per cycle, serialises special ops, waits in idle and counts stalls/dual issues.
module ibuf_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             id_ready,
    input  logic             a_valid,
    input  logic             b_valid,
    input  logic             a_is_spec_op,
    input  logic             a_is_idle,
    input  logic             a_have_excp,
    input  logic             a_is_br,
    input  logic             b_is_spec_op,
    input  logic             b_is_idle,
    input  logic             b_have_excp,
    input  logic             b_is_br,
    input  logic [4:0]       a_dest,
    input  logic [4:0]       b_dest,
    input  logic [4:0]       b_r1,
    input  logic [4:0]       b_r2,
    input  logic             b_src2_is_imm,
    input  logic             serial_done,
    input  logic             intr_pending,
    output logic [1:0]       o_size,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] dual_cnt
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SERIAL    = 2'd1,
        ST_IDLE_WAIT = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;
    logic [CNT_W-1:0] dual_cnt_reg;
    logic [CNT_W-1:0] dual_cnt_next;

    logic       in_run;
    logic       issue_ok;
    logic       a_single;
    logic       b_blocked;
    logic       raw_waw_hazard;
    logic [4:0] b_src [3];
    logic [2:0] b_src_read;
    logic [2:0] b_src_conflict;

    // The unused encoding behaves exactly like RUN.
    assign in_run = (state_reg != ST_SERIAL) && (state_reg != ST_IDLE_WAIT);

    assign issue_ok = resetn && !flush && in_run && id_ready && a_valid;
    assign a_single = a_is_spec_op || a_is_idle || a_have_excp || a_is_br;
    // A branch in slot b may still pair; only serialising/faulting entries block it.
    assign b_blocked = !b_valid || b_is_spec_op || b_is_idle || b_have_excp;

    // Operands of entry b that entry a's destination could collide with.
    assign b_src[0]   = b_r1;
    assign b_src[1]   = b_dest;
    assign b_src[2]   = b_r2;
    assign b_src_read = {!b_src2_is_imm, 1'b1, 1'b1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src_cmp
            assign b_src_conflict[gi] = b_src_read[gi] && (b_src[gi] == a_dest);
        end
    endgenerate

    // r0 is hardwired zero, so writes to it never create a dependency.
    assign raw_waw_hazard = (a_dest != 5'd0) && (|b_src_conflict);

    always_comb begin
        o_size = 2'd0;
        if (issue_ok) begin
            if (a_single || b_blocked || raw_waw_hazard) begin
                o_size = 2'd1;
            end else begin
                o_size = 2'd2;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SERIAL: begin
                if (serial_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_IDLE_WAIT: begin
                if (intr_pending) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
                if (o_size != 2'd0) begin
                    if (a_is_idle) begin
                        state_next = ST_IDLE_WAIT;
                    end else if (a_is_spec_op || a_have_excp) begin
                        state_next = ST_SERIAL;
                    end
                end
            end
        endcase
        if (flush) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        dual_cnt_next  = dual_cnt_reg;
        if (a_valid && (o_size == 2'd0) && !flush && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
        if (o_size == 2'd2) begin
            dual_cnt_next = dual_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_RUN;
            stall_cnt_reg <= '0;
            dual_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
            dual_cnt_reg  <= dual_cnt_next;
        end
    end

    assign state     = state_reg;
    assign stall_cnt = stall_cnt_reg;
    assign dual_cnt  = dual_cnt_reg;

endmodule

// File: tb/tb_ibuf_issue_ctrl.sv
// Bench for ibuf_issue_ctrl: vector table, directed FSM sequences and random
// stimulus against a behavioural model of the issue rules.
module tb_ibuf_issue_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush, id_ready, a_valid, b_valid;
    logic        a_is_spec_op, a_is_idle, a_have_excp, a_is_br;
    logic        b_is_spec_op, b_is_idle, b_have_excp, b_is_br;
    logic [4:0]  a_dest, b_dest, b_r1, b_r2;
    logic        b_src2_is_imm, serial_done, intr_pending;
    logic [1:0]  o_size, state;
    logic [15:0] stall_cnt, dual_cnt;

    ibuf_issue_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .id_ready(id_ready),
        .a_valid(a_valid), .b_valid(b_valid),
        .a_is_spec_op(a_is_spec_op), .a_is_idle(a_is_idle),
        .a_have_excp(a_have_excp), .a_is_br(a_is_br),
        .b_is_spec_op(b_is_spec_op), .b_is_idle(b_is_idle),
        .b_have_excp(b_have_excp), .b_is_br(b_is_br),
        .a_dest(a_dest), .b_dest(b_dest), .b_r1(b_r1), .b_r2(b_r2),
        .b_src2_is_imm(b_src2_is_imm), .serial_done(serial_done),
        .intr_pending(intr_pending), .o_size(o_size), .state(state),
        .stall_cnt(stall_cnt), .dual_cnt(dual_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = running, 1 = waiting for serial commit, 2 = waiting for interrupt.
    int m_state = 0;
    int m_stall = 0;
    int m_dual  = 0;

    typedef struct {
        string      name;
        logic       av, bv;
        logic [3:0] aattr;   // {spec, idle, excp, br}
        logic [2:0] battr;   // {spec, idle, excp}
        logic [4:0] ad, bd, r1, r2;
        logic       imm, idr, fl;
        int         exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic int model_size();
        logic hazard;
        if (!resetn || flush || m_state != 0 || !id_ready || !a_valid) return 0;
        if (a_is_spec_op || a_is_idle || a_have_excp || a_is_br) return 1;
        if (!b_valid || b_is_spec_op || b_is_idle || b_have_excp) return 1;
        hazard = (a_dest != 0) &&
                 (a_dest == b_r1 || a_dest == b_dest || (!b_src2_is_imm && a_dest == b_r2));
        return hazard ? 1 : 2;
    endfunction

    task automatic clr();
        flush = 0; id_ready = 1; a_valid = 0; b_valid = 0;
        a_is_spec_op = 0; a_is_idle = 0; a_have_excp = 0; a_is_br = 0;
        b_is_spec_op = 0; b_is_idle = 0; b_have_excp = 0; b_is_br = 0;
        a_dest = 0; b_dest = 0; b_r1 = 0; b_r2 = 0;
        b_src2_is_imm = 0; serial_done = 0; intr_pending = 0;
    endtask

    // One clock: check o_size before the edge, advance the model, check registered state after.
    // exp < 0 takes the expected size from the model.
    task automatic cycle(input string tag, input int exp, input bit quiet);
        int sz;
        #1;
        sz = model_size();
        if (!quiet) chk({tag, ".o_size"}, int'(o_size), (exp < 0) ? sz : exp);
        @(posedge clk);
        if (flush) m_state = 0;
        else if (m_state == 0) begin
            if (sz >= 1 && a_is_idle) m_state = 2;
            else if (sz >= 1 && (a_is_spec_op || a_have_excp)) m_state = 1;
        end else if (m_state == 1) begin
            if (serial_done) m_state = 0;
        end else if (intr_pending) m_state = 0;
        if (a_valid && sz == 0 && !flush && m_stall < 65535) m_stall++;
        if (sz == 2) m_dual = (m_dual + 1) % 65536;
        #1;
        if (!quiet) begin
            chk({tag, ".state"}, int'(state), m_state);
            chk({tag, ".stall_cnt"}, int'(stall_cnt), m_stall);
            chk({tag, ".dual_cnt"}, int'(dual_cnt), m_dual);
            $display("[%0t] %s: o_size=%0d state=%0d stall=%0d dual=%0d",
                     $time, tag, sz, state, stall_cnt, dual_cnt);
        end
    endtask

    function automatic vec_t mk(string n, logic av, logic bv, logic [3:0] aa, logic [2:0] ba,
                                logic [4:0] ad, logic [4:0] bd, logic [4:0] r1, logic [4:0] r2,
                                logic imm, logic idr, logic fl, int exp);
        vec_t v;
        v.name = n; v.av = av; v.bv = bv; v.aattr = aa; v.battr = ba;
        v.ad = ad; v.bd = bd; v.r1 = r1; v.r2 = r2; v.imm = imm; v.idr = idr; v.fl = fl;
        v.exp = exp;
        return v;
    endfunction

    // Async reset asserted between edges: state and counters must clear without a clock.
    task automatic async_reset(input string tag);
        #2;
        resetn = 0;
        #1;
        chk({tag, ".state"}, int'(state), 0);
        chk({tag, ".stall_cnt"}, int'(stall_cnt), 0);
        chk({tag, ".dual_cnt"}, int'(dual_cnt), 0);
        chk({tag, ".o_size"}, int'(o_size), 0);
        $display("[%0t] %s: reset asserted mid-cycle", $time, tag);
        m_state = 0; m_stall = 0; m_dual = 0;
        #3;
        resetn = 1;
    endtask

    int stall0;

    initial begin
        clr();
        a_valid = 1; b_valid = 1;
        resetn = 0;
        #3;
        chk("reset.o_size", int'(o_size), 0);
        chk("reset.state", int'(state), 0);
        chk("reset.stall_cnt", int'(stall_cnt), 0);
        chk("reset.dual_cnt", int'(dual_cnt), 0);
        $display("[%0t] reset: o_size=%0d state=%0d", $time, o_size, state);
        #9;
        resetn = 1;   // t=12, between edges; the first vector issues on the next edge

        tbl.push_back(mk("pair",       1, 1, 4'b0000, 3'b000, 5, 8, 6, 7, 0, 1, 0, 2));
        tbl.push_back(mk("raw_r2",     1, 1, 4'b0000, 3'b000, 5, 8, 6, 5, 0, 1, 0, 1));
        tbl.push_back(mk("raw_r2_imm", 1, 1, 4'b0000, 3'b000, 5, 8, 6, 5, 1, 1, 0, 2));
        tbl.push_back(mk("r0_dest",    1, 1, 4'b0000, 3'b000, 0, 8, 0, 7, 0, 1, 0, 2));
        tbl.push_back(mk("r0_all",     1, 1, 4'b0000, 3'b000, 0, 0, 0, 0, 0, 1, 0, 2));
        tbl.push_back(mk("raw_r1",     1, 1, 4'b0000, 3'b000, 5, 8, 5, 7, 0, 1, 0, 1));
        tbl.push_back(mk("waw",        1, 1, 4'b0000, 3'b000, 5, 5, 6, 7, 0, 1, 0, 1));
        tbl.push_back(mk("b_invalid",  1, 0, 4'b0000, 3'b000, 5, 8, 6, 7, 0, 1, 0, 1));
        tbl.push_back(mk("b_spec",     1, 1, 4'b0000, 3'b100, 5, 8, 6, 7, 0, 1, 0, 1));
        tbl.push_back(mk("b_idle",     1, 1, 4'b0000, 3'b010, 5, 8, 6, 7, 0, 1, 0, 1));
        tbl.push_back(mk("b_excp",     1, 1, 4'b0000, 3'b001, 5, 8, 6, 7, 0, 1, 0, 1));
        tbl.push_back(mk("a_br",       1, 1, 4'b0001, 3'b000, 5, 8, 6, 7, 0, 1, 0, 1));
        tbl.push_back(mk("id_busy",    1, 1, 4'b0000, 3'b000, 5, 8, 6, 7, 0, 0, 0, 0));
        tbl.push_back(mk("a_invalid",  0, 1, 4'b0000, 3'b000, 5, 8, 6, 7, 0, 1, 0, 0));
        tbl.push_back(mk("flush",      1, 1, 4'b0000, 3'b000, 5, 8, 6, 7, 0, 1, 1, 0));
        tbl.push_back(mk("spec_busy",  1, 1, 4'b1000, 3'b000, 5, 8, 6, 7, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            clr();
            a_valid = tbl[i].av; b_valid = tbl[i].bv;
            {a_is_spec_op, a_is_idle, a_have_excp, a_is_br} = tbl[i].aattr;
            {b_is_spec_op, b_is_idle, b_have_excp} = tbl[i].battr;
            a_dest = tbl[i].ad; b_dest = tbl[i].bd; b_r1 = tbl[i].r1; b_r2 = tbl[i].r2;
            b_src2_is_imm = tbl[i].imm; id_ready = tbl[i].idr; flush = tbl[i].fl;
            cycle(tbl[i].name, tbl[i].exp, 0);
        end

        // Serialisation: issue spec op, stall three cycles, release on serial_done.
        clr(); a_valid = 1; a_is_spec_op = 1; a_dest = 3;
        cycle("ser_issue", 1, 0);
        chk("ser_issue.state_is_serial", int'(state), 1);
        stall0 = int'(stall_cnt);
        clr(); a_valid = 1; b_valid = 1; a_dest = 5; b_r1 = 6; b_r2 = 7; b_dest = 8;
        for (int k = 0; k < 3; k++) cycle("ser_stall", 0, 0);
        chk("ser_stall.delta", int'(stall_cnt) - stall0, 3);
        serial_done = 1;
        cycle("ser_done", 0, 0);
        chk("ser_done.state_run", int'(state), 0);

        // Idle wake: idle has priority over spec op.
        clr(); a_valid = 1; a_is_idle = 1; a_is_spec_op = 1;
        cycle("idle_issue", 1, 0);
        chk("idle_issue.state_idle", int'(state), 2);
        clr(); a_valid = 1; intr_pending = 1;
        cycle("idle_wake", 0, 0);
        clr(); a_valid = 1; b_valid = 1; a_dest = 5; b_r1 = 6; b_r2 = 7; b_dest = 8;
        cycle("idle_resume", 2, 0);

        // Flush overrides a pending SERIAL wait.
        clr(); a_valid = 1; a_have_excp = 1;
        cycle("excp_issue", 1, 0);
        clr(); a_valid = 1; flush = 1;
        cycle("flush_serial", 0, 0);
        chk("flush_serial.state_run", int'(state), 0);

        // Flush coincident with intr_pending in IDLE_WAIT.
        clr(); a_valid = 1; a_is_idle = 1;
        cycle("idle_issue2", 1, 0);
        clr(); flush = 1; intr_pending = 1;
        cycle("flush_idle", 0, 0);

        // Reset in the middle of SERIAL.
        clr(); a_valid = 1; a_is_spec_op = 1;
        cycle("ser_issue2", 1, 0);
        clr(); a_valid = 1;
        cycle("ser_stall2", 0, 0);
        async_reset("reset_in_serial");
        clr(); a_valid = 1; b_valid = 1; a_dest = 1; b_r1 = 2; b_r2 = 3; b_dest = 4;
        cycle("post_reset_issue", 2, 0);

        // Randomised traffic with narrow register ranges to provoke hazards.
        for (int k = 0; k < 400; k++) begin
            flush         = ($urandom_range(0, 15) == 0);
            id_ready      = ($urandom_range(0, 3) != 0);
            a_valid       = ($urandom_range(0, 4) != 0);
            b_valid       = $urandom_range(0, 1);
            a_is_spec_op  = ($urandom_range(0, 11) == 0);
            a_is_idle     = ($urandom_range(0, 15) == 0);
            a_have_excp   = ($urandom_range(0, 15) == 0);
            a_is_br       = ($urandom_range(0, 5) == 0);
            b_is_spec_op  = ($urandom_range(0, 7) == 0);
            b_is_idle     = ($urandom_range(0, 11) == 0);
            b_have_excp   = ($urandom_range(0, 11) == 0);
            b_is_br       = $urandom_range(0, 1);
            a_dest        = 5'($urandom_range(0, 3));
            b_dest        = 5'($urandom_range(0, 3));
            b_r1          = 5'($urandom_range(0, 3));
            b_r2          = 5'($urandom_range(0, 3));
            b_src2_is_imm = $urandom_range(0, 1);
            serial_done   = ($urandom_range(0, 3) == 0);
            intr_pending  = ($urandom_range(0, 3) == 0);
            cycle("rand", -1, 0);
        end

        clr(); flush = 1;
        cycle("rand_exit_flush", 0, 0);

        // Saturation: park in IDLE_WAIT with a valid head until stall_cnt pins at all-ones.
        clr(); a_valid = 1; a_is_idle = 1;
        cycle("sat_idle", 1, 0);
        clr(); a_valid = 1;
        for (int k = 0; k < 65540; k++) cycle("sat_fill", 0, 1);
        chk("sat.stall_cnt_full", int'(stall_cnt), 65535);
        cycle("sat_hold", 0, 0);
        cycle("sat_hold", 0, 0);

        // Reset in the middle of IDLE_WAIT clears the saturated counter.
        async_reset("reset_in_idle");
        clr(); a_valid = 1; b_valid = 1; a_dest = 9; b_r1 = 10; b_r2 = 11; b_dest = 12;
        cycle("final_issue", 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
